// File: rtl/servo_scan_if.sv
// Bus between a scan-sequencer client and servo_scan_ctrl: sweep configuration
// and servo-driver tick in one direction, commanded angle and status in the other.
interface servo_scan_if #(
    parameter int ANGLE_W = 8,
    parameter int STEP_W  = 4
);
    logic               servo_cycle_done;
    logic               move_en;
    logic [ANGLE_W-1:0] start_angle;
    logic [ANGLE_W-1:0] end_angle;
    logic [STEP_W-1:0]  step;
    logic               mode;
    logic               restart;
    logic [ANGLE_W-1:0] servo_angle;
    logic               servo_dir;
    logic               at_limit;
    logic               sweep_done;

    modport master (
        output servo_cycle_done, move_en, start_angle, end_angle, step, mode, restart,
        input  servo_angle, servo_dir, at_limit, sweep_done
    );

    modport slave (
        input  servo_cycle_done, move_en, start_angle, end_angle, step, mode, restart,
        output servo_angle, servo_dir, at_limit, sweep_done
    );
endinterface

// File: rtl/servo_scan_ctrl.sv
// Servo sweep sequencer: steps a commanded angle between two bounds, one step
// per PWM_CYCLES_PER_ITER servo cycles, bouncing or stopping at the far limit.
module servo_scan_ctrl #(
    parameter int ANGLE_W             = 8,
    parameter int STEP_W              = 4,
    parameter int PWM_CYCLES_PER_ITER = 1,
    parameter int DWELL_ITERS         = 0
) (
    input  logic        clk,
    input  logic        rst,
    servo_scan_if.slave bus
);
    localparam int                 AW1         = ANGLE_W + 1;
    localparam logic [15:0]        DIV_RELOAD  = 16'(PWM_CYCLES_PER_ITER - 1);
    localparam logic [7:0]         DWELL_LOAD  = 8'(DWELL_ITERS);
    localparam logic [ANGLE_W-1:0] ANGLE_RESET = {1'b1, {(ANGLE_W-1){1'b0}}};

    typedef enum logic [1:0] {ST_WAIT, ST_DIVIDE, ST_UPDATE, ST_DONE} state_t;

    state_t             state_q;
    logic [ANGLE_W-1:0] angle_q;
    logic               dir_q;
    logic               at_limit_q;
    logic               sweep_done_q;
    logic [15:0]        div_cnt_q;
    logic [7:0]         dwell_cnt_q;

    logic [ANGLE_W-1:0] lo;
    logic [ANGLE_W-1:0] hi;
    logic [AW1-1:0]     step_ext;
    logic [AW1-1:0]     sum_up;
    logic [AW1-1:0]     diff_dn;
    logic [ANGLE_W-1:0] up_sat;
    logic [ANGLE_W-1:0] dn_sat;
    logic [ANGLE_W-1:0] moved_angle;
    logic               moved_hit;

    logic [ANGLE_W-1:0] upd_angle_d;
    logic               upd_dir_d;
    logic               upd_limit_d;
    logic               upd_done_d;

    // Bounds may arrive in either order; normalise them every cycle.
    assign lo = (bus.start_angle <= bus.end_angle) ? bus.start_angle : bus.end_angle;
    assign hi = (bus.start_angle <= bus.end_angle) ? bus.end_angle   : bus.start_angle;

    // One extra bit of headroom so neither direction can wrap before saturation.
    assign step_ext    = AW1'(bus.step);
    assign sum_up      = {1'b0, angle_q} + step_ext;
    assign diff_dn     = {1'b0, angle_q} - step_ext;
    assign up_sat      = (sum_up > {1'b0, hi}) ? hi : sum_up[ANGLE_W-1:0];
    assign dn_sat      = (diff_dn[ANGLE_W] || (diff_dn[ANGLE_W-1:0] < lo)) ? lo : diff_dn[ANGLE_W-1:0];
    assign moved_angle = dir_q ? dn_sat : up_sat;
    assign moved_hit   = dir_q ? (moved_angle == lo) : (moved_angle == hi);

    // Outcome of an UPDATE cycle: degenerate window, out-of-window correction, or a normal step.
    always_comb begin
        upd_angle_d = angle_q;
        upd_dir_d   = dir_q;
        upd_limit_d = 1'b0;
        upd_done_d  = 1'b0;
        if (lo == hi) begin
            upd_angle_d = lo;
            upd_done_d  = bus.mode;
        end else if (angle_q < lo) begin
            upd_angle_d = lo;
            upd_dir_d   = 1'b0;
        end else if (angle_q > hi) begin
            upd_angle_d = hi;
            upd_dir_d   = 1'b1;
        end else if (bus.step != '0) begin
            upd_angle_d = moved_angle;
            if (moved_hit) begin
                upd_limit_d = 1'b1;
                upd_dir_d   = ~dir_q;
                // Only the upward arrival at hi finishes a one-shot sweep.
                upd_done_d  = bus.mode & ~dir_q;
            end
        end
    end

    // Sequencer FSM with registered outputs; rst beats restart, restart beats everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_WAIT;
            angle_q      <= ANGLE_RESET;
            dir_q        <= 1'b0;
            at_limit_q   <= 1'b0;
            sweep_done_q <= 1'b0;
            div_cnt_q    <= DIV_RELOAD;
            dwell_cnt_q  <= 8'd0;
        end else if (bus.restart) begin
            state_q      <= ST_WAIT;
            angle_q      <= lo;
            dir_q        <= 1'b0;
            at_limit_q   <= 1'b0;
            sweep_done_q <= 1'b0;
            div_cnt_q    <= DIV_RELOAD;
            dwell_cnt_q  <= 8'd0;
        end else begin
            at_limit_q <= 1'b0;
            case (state_q)
                ST_WAIT: begin
                    if (bus.servo_cycle_done) begin
                        state_q <= ST_DIVIDE;
                    end
                end
                ST_DIVIDE: begin
                    if (div_cnt_q != 16'd0) begin
                        div_cnt_q <= div_cnt_q - 16'd1;
                        state_q   <= ST_WAIT;
                    end else begin
                        div_cnt_q <= DIV_RELOAD;
                        if (!bus.move_en) begin
                            state_q <= ST_WAIT;
                        end else if (dwell_cnt_q != 8'd0) begin
                            dwell_cnt_q <= dwell_cnt_q - 8'd1;
                            state_q     <= ST_WAIT;
                        end else begin
                            state_q <= ST_UPDATE;
                        end
                    end
                end
                ST_UPDATE: begin
                    angle_q    <= upd_angle_d;
                    dir_q      <= upd_dir_d;
                    at_limit_q <= upd_limit_d;
                    if (upd_limit_d) begin
                        dwell_cnt_q <= DWELL_LOAD;
                    end
                    if (upd_done_d) begin
                        state_q      <= ST_DONE;
                        sweep_done_q <= 1'b1;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_DONE;
                end
                default: begin
                    state_q <= ST_WAIT;
                end
            endcase
        end
    end

    assign bus.servo_angle = angle_q;
    assign bus.servo_dir   = dir_q;
    assign bus.at_limit    = at_limit_q;
    assign bus.sweep_done  = sweep_done_q;
endmodule
